// File: rtl/digit_entry_unit.sv
// Four-channel push-button front end: synchronise, debounce, and count presses
// into decimal digits for the operations stage.
module digit_entry_unit #(
  parameter int unsigned DEB_CYCLES = 20,
  parameter int unsigned MAX_DIGIT  = 9
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       clr,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] press,
  output logic       any_held
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] DIG_MAX  = 4'(MAX_DIGIT);

  logic [3:0] s1;
  logic [3:0] s2;
  state_t     state   [4];
  state_t     state_n [4];
  logic [7:0] cnt     [4];
  logic [7:0] cnt_n   [4];
  logic [3:0] dig     [4];
  logic [3:0] dig_n   [4];
  logic [3:0] inc;
  logic [3:0] held_n;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      inc[i]     = 1'b0;
      case (state[i])
        RELEASED: begin
          if (s2[i]) begin
            state_n[i] = PRESS_CHK;
            cnt_n[i]   = 8'd1;
          end
        end
        PRESS_CHK: begin
          if (!s2[i]) begin
            state_n[i] = RELEASED;
            cnt_n[i]   = 8'd0;
          end else if (cnt[i] == CNT_LAST) begin
            state_n[i] = HELD;
            inc[i]     = 1'b1;
          end else begin
            cnt_n[i] = cnt[i] + 8'd1;
          end
        end
        HELD: begin
          if (!s2[i]) begin
            state_n[i] = RELEASE_CHK;
            cnt_n[i]   = 8'd1;
          end
        end
        RELEASE_CHK: begin
          if (s2[i]) begin
            state_n[i] = HELD;
          end else if (cnt[i] == CNT_LAST) begin
            state_n[i] = RELEASED;
          end else begin
            cnt_n[i] = cnt[i] + 8'd1;
          end
        end
      endcase
      held_n[i] = (state_n[i] == HELD) || (state_n[i] == RELEASE_CHK);
      // clr wins over a same-cycle increment; press still pulses
      if (clr)
        dig_n[i] = '0;
      else if (inc[i])
        dig_n[i] = (dig[i] == DIG_MAX) ? '0 : dig[i] + 4'd1;
      else
        dig_n[i] = dig[i];
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      press    <= '0;
      any_held <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
        dig[i]   <= '0;
      end
    end else begin
      s1       <= btn;
      s2       <= s1;
      press    <= inc;
      any_held <= |held_n;
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
        dig[i]   <= dig_n[i];
      end
    end
  end

  assign digit1 = dig[0];
  assign digit2 = dig[1];
  assign digit3 = dig[2];
  assign digit4 = dig[3];

endmodule

// File: tb/tb_digit_entry_unit.sv
// Directed bench for digit_entry_unit with DEB_CYCLES=4; a second instance with
// MAX_DIGIT=5 shares the stimulus to check the alternate wrap point.
module tb_digit_entry_unit;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b0;
  logic [3:0] btn  = '0;
  logic       clr  = 1'b0;
  logic [3:0] digit1, digit2, digit3, digit4, press;
  logic       any_held;
  logic [3:0] b_digit1, b_digit2, b_digit3, b_digit4, b_press;
  logic       b_any_held;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [3:0]  exp_d [4];
  logic [3:0]  exp_b3;

  digit_entry_unit #(.DEB_CYCLES(4), .MAX_DIGIT(9)) dut (
    .clk1(clk1), .rst(rst), .btn(btn), .clr(clr),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .press(press), .any_held(any_held)
  );

  digit_entry_unit #(.DEB_CYCLES(4), .MAX_DIGIT(5)) dut_b (
    .clk1(clk1), .rst(rst), .btn(btn), .clr(clr),
    .digit1(b_digit1), .digit2(b_digit2), .digit3(b_digit3), .digit4(b_digit4),
    .press(b_press), .any_held(b_any_held)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [3:0]  btn;
    logic        clr;
    logic [15:0] digits;  // {digit4, digit3, digit2, digit1}
    logic [3:0]  press;
    logic        held;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] exp_pack();
    return {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
  endfunction

  function automatic logic [15:0] dut_pack();
    return {digit4, digit3, digit2, digit1};
  endfunction

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [3:0] next_dig(input logic [3:0] d, input logic [3:0] mx);
    return (d == mx) ? 4'd0 : d + 4'd1;
  endfunction

  // Clean press on the channels in mask, optional clr on the update edge, then clean release.
  task automatic do_press(input logic [3:0] mask, input logic with_clr);
    btn = mask;
    for (int k = 0; k < 5; k++) begin
      step();
      check("press_early", {12'd0, press}, 16'd0);
    end
    check("digits_before_update", dut_pack(), exp_pack());
    clr = with_clr;
    step();
    for (int i = 0; i < 4; i++)
      if (with_clr) exp_d[i] = '0;
      else if (mask[i]) exp_d[i] = next_dig(exp_d[i], 4'd9);
    if (with_clr) exp_b3 = '0;
    else if (mask[2]) exp_b3 = next_dig(exp_b3, 4'd5);
    check("digits_update", dut_pack(), exp_pack());
    check("press_pulse", {12'd0, press}, {12'd0, mask});
    check("held_rise", {15'd0, any_held}, 16'd1);
    check("wrap5_digit3", {12'd0, b_digit3}, {12'd0, exp_b3});
    clr = 1'b0;
    btn = '0;
    step();
    check("press_one_cycle", {12'd0, press}, 16'd0);
    for (int k = 0; k < 5; k++) step();
    check("released_held", {15'd0, any_held}, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_d[i] = '0;
    exp_b3 = '0;

    // Channel 0 press/hold/release, rows indexed by edge after btn[0] rises.
    for (int k = 0; k < 16; k++) begin
      tbl[k].btn    = (k < 10) ? 4'b0001 : 4'b0000;
      tbl[k].clr    = 1'b0;
      tbl[k].digits = (k >= 5) ? 16'h0001 : 16'h0000;
      tbl[k].press  = (k == 5) ? 4'b0001 : 4'b0000;
      tbl[k].held   = (k >= 5) && (k <= 14);
    end

    // Reset state
    step();
    step();
    check("reset_digits", dut_pack(), 16'd0);
    check("reset_press", {12'd0, press}, 16'd0);
    check("reset_held", {15'd0, any_held}, 16'd0);
    rst = 1'b1;
    step();
    step();
    check("idle_digits", dut_pack(), 16'd0);

    for (int k = 0; k < 16; k++) begin
      btn = tbl[k].btn;
      clr = tbl[k].clr;
      step();
      check($sformatf("tbl%0d_digits", k), dut_pack(), tbl[k].digits);
      check($sformatf("tbl%0d_press", k), {12'd0, press}, {12'd0, tbl[k].press});
      check($sformatf("tbl%0d_held", k), {15'd0, any_held}, {15'd0, tbl[k].held});
    end
    exp_d[0] = 4'd1;
    step();

    // Release glitch while HELD
    btn = 4'b0001;
    for (int k = 0; k < 6; k++) step();
    exp_d[0] = 4'd2;
    check("glitch_pre_digits", dut_pack(), exp_pack());
    step();
    step();
    btn = 4'b0000;
    step();
    btn = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      check("glitch_press", {12'd0, press}, 16'd0);
      check("glitch_held", {15'd0, any_held}, 16'd1);
    end
    check("glitch_digits", dut_pack(), exp_pack());
    btn = '0;
    for (int k = 0; k < 7; k++) step();
    check("glitch_released", {15'd0, any_held}, 16'd0);

    // Bounce rejection on channel 1
    begin
      logic [5:0] pat;
      pat = 6'b011011;
      for (int k = 0; k < 6; k++) begin
        btn = {2'b00, pat[k], 1'b0};
        step();
        check("bounce_press", {12'd0, press}, 16'd0);
      end
      btn = '0;
      for (int k = 0; k < 4; k++) begin
        step();
        check("bounce_press_tail", {12'd0, press}, 16'd0);
      end
      check("bounce_digits", dut_pack(), exp_pack());
      check("bounce_held", {15'd0, any_held}, 16'd0);
    end

    // Wrap-around on channel 2 (MAX 9 and MAX 5)
    for (int p = 0; p < 10; p++) do_press(4'b0100, 1'b0);
    check("wrap9_final", {12'd0, digit3}, 16'd0);

    // Simultaneous presses, then simultaneous presses with clr on the update edge
    do_press(4'b1111, 1'b0);
    do_press(4'b1111, 1'b1);
    check("clr_digits_zero", dut_pack(), 16'd0);

    // Reset mid-press on channel 3, button held through reset release
    btn = 4'b1000;
    for (int k = 0; k < 4; k++) step();
    #2 rst = 1'b0;
    #1;
    check("midrst_digits", dut_pack(), 16'd0);
    check("midrst_press", {12'd0, press}, 16'd0);
    step();
    step();
    check("midrst_hold_digits", dut_pack(), 16'd0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("midrst_wait_digits", dut_pack(), 16'd0);
    end
    step();
    check("midrst_repress_digits", dut_pack(), 16'h1000);
    check("midrst_repress_press", {12'd0, press}, 16'h0008);
    btn = '0;
    for (int k = 0; k < 8; k++) step();
    check("final_digits", dut_pack(), 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_entry_unit.md
# digit_entry_unit

Front-end digit entry for the four-digit calculator: takes the four raw operand push-buttons and produces four clean decimal digit values, one per button, consumed by the operations stage. Each channel synchronises its button, debounces it with a per-channel state machine, and advances a mod-(MAX_DIGIT+1) digit counter once per debounced press. It runs on the divided system clock that also drives the display multiplexer, and it replaces the per-button incrementor chain.

## Interface
- DEB_CYCLES, 20: consecutive stable synchronised samples required to accept a level change; legal range 2..255.
- MAX_DIGIT, 9: highest digit value, after which the digit wraps to 0; legal range 1..15.
- clk1  input  1  divided system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, no other reset.
- btn  input  4  raw buttons, active-high, asynchronous; btn[0] drives digit1 … btn[3] drives digit4.
- clr  input  1  synchronous clear of all four digits, active-high.
- digit1, digit2, digit3, digit4  output  4 each  current digit value, 0..MAX_DIGIT.
- press  output  4  one-cycle pulse per channel on an accepted press.
- any_held  output  1  high while any channel is in HELD or RELEASE_CHK.

## Operation
- Per channel: two-flop synchroniser s1→s2 (both reset to 0), then FSM with an 8-bit sample counter cnt.
- FSM states: RELEASED, PRESS_CHK, HELD, RELEASE_CHK. Reset state RELEASED, cnt=0.
- RELEASED: s2=1 → PRESS_CHK, cnt=1; else stay.
- PRESS_CHK: s2=0 → RELEASED, cnt=0 (bounce rejected, no increment); s2=1 and cnt==DEB_CYCLES-1 → HELD, digit increments, press pulses; s2=1 otherwise → cnt+1.
- HELD: s2=0 → RELEASE_CHK, cnt=1; else stay. Holding never auto-repeats.
- RELEASE_CHK: s2=1 → HELD, no increment; s2=0 and cnt==DEB_CYCLES-1 → RELEASED; s2=0 otherwise → cnt+1.
- Digit arithmetic: 4-bit unsigned; digit==MAX_DIGIT on increment → 0, else digit+1.
- clr=1: all digits → 0 on that edge; clr takes priority over a same-cycle increment (digit ends at 0, press still pulses). clr does not affect FSMs or synchronisers.
- Channels are fully independent; simultaneous presses on several channels each increment their own digit in the same cycle.
- Reset values: digit1..digit4=0, press=0, any_held=0, all FSMs RELEASED.
- Reset asserted mid-operation: all state clears immediately and asynchronously; no partial increment survives.
- Button held through reset deassertion: synchroniser starts at 0 and then sees 1, so the button is treated as a new press and increments once after the normal latency.

## Timing
- Button first sampled high at edge N: s1=1 at N, s2=1 at N+1, PRESS_CHK entered at N+2, HELD plus digit update at edge N+1+DEB_CYCLES.
- press[i] is high for exactly the one cycle following edge N+1+DEB_CYCLES. It is registered and glitch-free.
- Release: s2 low for DEB_CYCLES consecutive samples returns the channel to RELEASED. A new press can start on the next edge.
- Minimum press-to-press spacing: 2·DEB_CYCLES cycles of stable levels.
- Digit outputs are registered and change only on clk1 rising edges (or asynchronously on reset).
- clr takes effect at the edge it is sampled, with no added latency.
- any_held is registered and decoded from the next-state value, so it rises on the same edge as the digit update.

## Test plan
- Reset, DEB_CYCLES=4: hold btn[0] high for 10 cycles starting at edge 0 → digit1=1 from edge 5, press[0] high for one cycle after edge 5, other digits stay 0, no further increment while held.
- Bounce rejection, DEB_CYCLES=4: btn[1] pattern 1,1,0,1,1,0 → PRESS_CHK aborts each time, digit2 stays 0, press never pulses.
- Wrap-around, MAX_DIGIT=9: 10 clean presses on btn[2] → digit3 runs 1..9 and then 0. With MAX_DIGIT=5, the 6th press gives 0.
- Simultaneous events: all four buttons pressed at the same edge → all digits become 1 on the same edge. clr asserted on that edge → all digits 0 while press=4'b1111.
- Reset mid-press: rst low while channel 3 is in PRESS_CHK at cnt=2 → digit4 stays 0 and press stays 0; btn[3] still high after rst deasserts → digit4=1 at edge 1+DEB_CYCLES after the first sample.
- Release glitch: while HELD, a one-cycle low on btn[0] → returns to HELD, no second increment, any_held stays 1.
